spi_tx_top: RTL and testbench

Self-contained SPI transmit source for the 50 MHz system clock domain. While `top_valid` is high it emits back-to-back SPI frames (mode 0, MSB first), each carrying the next value of an internal incrementing word counter. It sits at chip top and drives an external SPI slave through `spi_cs`, `spi_clk` and `spi_data`.

---
 rtl/spi_tx_pkg.sv | 27 ++
 rtl/spi_tx_shifter.sv | 106 ++++++++++
 rtl/spi_tx_top.sv | 81 ++++++++
 tb/tb_spi_tx_top.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_tx_pkg.sv
// Shared state encoding, default timing and counter helpers
// for the SPI transmit source.
package spi_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_e;

   localparam int          DEF_DATA_W    = 16;
   localparam int          DEF_CLK_DIV   = 4;
   localparam int          DEF_CS_SETUP  = 2;
   localparam int          DEF_CS_HOLD   = 2;
   localparam int          DEF_GAP       = 4;
   localparam logic [15:0] DEF_INIT_WORD = 16'hA5A5;

   localparam int CNT_W = 16;

   // Terminal value of a counter that runs n cycles starting at zero.
   function automatic logic [CNT_W-1:0] last(input int n);
      return CNT_W'(n - 1);
   endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Frame sequencer: chip-select setup, mode-0 bit shifting (MSB first)
// and chip-select hold, started by a one-cycle start/load_word handshake.
module spi_tx_shifter
   import spi_tx_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int CS_SETUP = DEF_CS_SETUP,
   parameter int CS_HOLD  = DEF_CS_HOLD
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] load_word_i,
   output logic              done_o,
   output logic              cs_o,
   output logic              sclk_o,
   output logic              sdo_o
);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  bit_q;
   logic [DATA_W-1:0] shreg_q;
   logic              cs_q;
   logic              sclk_q;
   logic              sdo_q;

   // Combinational so the controller enters GAP exactly as chip select rises.
   assign done_o = (state_q == S_HOLD) && (cnt_q == last(CS_HOLD));

   assign cs_o   = cs_q;
   assign sclk_o = sclk_q;
   assign sdo_o  = sdo_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b0;
         sdo_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               cs_q   <= 1'b1;
               sclk_q <= 1'b0;
               sdo_q  <= 1'b0;
               if (start_i) begin
                  state_q <= S_SETUP;
                  cnt_q   <= '0;
                  shreg_q <= load_word_i;
                  cs_q    <= 1'b0;
                  sdo_q   <= load_word_i[DATA_W-1];
               end
            end
            S_SETUP: begin
               if (cnt_q == last(CS_SETUP)) begin
                  state_q <= S_SHIFT;
                  cnt_q   <= '0;
                  bit_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_SHIFT: begin
               if (cnt_q == last(CLK_DIV / 2)) begin
                  sclk_q <= 1'b1;
               end
               if (cnt_q == last(CLK_DIV)) begin
                  sclk_q <= 1'b0;
                  cnt_q  <= '0;
                  if (bit_q == last(DATA_W)) begin
                     state_q <= S_HOLD;
                     sdo_q   <= 1'b0;
                  end else begin
                     bit_q   <= bit_q + CNT_W'(1);
                     shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
                     sdo_q   <= shreg_q[DATA_W-2];
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (cnt_q == last(CS_HOLD)) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  cs_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               cs_q    <= 1'b1;
               sclk_q  <= 1'b0;
               sdo_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/spi_tx_top.sv
// SPI transmit source: streams frames carrying an incrementing word
// while top_valid is high; owns IDLE/GAP control and the word counter.
module spi_tx_top
   import spi_tx_pkg::*;
#(
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                CLK_DIV   = DEF_CLK_DIV,
   parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(DEF_INIT_WORD),
   parameter int                CS_SETUP  = DEF_CS_SETUP,
   parameter int                CS_HOLD   = DEF_CS_HOLD,
   parameter int                GAP       = DEF_GAP
) (
   input  logic clk,
   input  logic RSTn,
   input  logic top_valid,
   output logic spi_cs,
   output logic spi_clk,
   output logic spi_data
);

   state_e            state_q;
   logic [CNT_W-1:0]  gap_q;
   logic [DATA_W-1:0] word_q;
   logic [DATA_W-1:0] word_d;
   logic              start;
   logic              done;

   always_comb begin
      start  = (state_q == S_IDLE) && top_valid;
      word_d = word_q + DATA_W'(1);
   end

   // While the shifter walks SETUP/SHIFT/HOLD this FSM parks in S_SETUP.
   always_ff @(posedge clk) begin
      if (RSTn) begin
         state_q <= S_IDLE;
         gap_q   <= '0;
         word_q  <= INIT_WORD;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_SETUP;
               end
            end
            S_SETUP, S_SHIFT, S_HOLD: begin
               if (done) begin
                  state_q <= S_GAP;
                  gap_q   <= '0;
               end
            end
            S_GAP: begin
               if (gap_q == last(GAP)) begin
                  state_q <= S_IDLE;
                  word_q  <= word_d;
               end else begin
                  gap_q <= gap_q + CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   spi_tx_shifter #(
      .DATA_W   (DATA_W),
      .CLK_DIV  (CLK_DIV),
      .CS_SETUP (CS_SETUP),
      .CS_HOLD  (CS_HOLD)
   ) u_shifter (
      .clk_i       (clk),
      .rst_i       (RSTn),
      .start_i     (start),
      .load_word_i (word_q),
      .done_o      (done),
      .cs_o        (spi_cs),
      .sclk_o      (spi_clk),
      .sdo_o       (spi_data)
   );

endmodule

// File: tb/tb_spi_tx_top.sv
// Bench for spi_tx_top: a default instance and an INIT_WORD=FFFF instance,
// decoded by a bus monitor and compared against an arithmetic frame model.
module tb_spi_tx_top;

   localparam logic [15:0] INIT_W [2] = '{16'hA5A5, 16'hFFFF};
   localparam int CS_LOW  = 2 + 16 * 4 + 2;
   localparam int PERIOD  = 1 + CS_LOW + 4;
   localparam int FIRST_R = 2 + 4 / 2;

   logic       clk = 1'b0;
   logic       RSTn;
   logic [1:0] tv;
   logic [1:0] cs;
   logic [1:0] sck;
   logic [1:0] sdo;

   int n_tests = 0;
   int n_fail  = 0;

   always #10 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      spi_tx_top #(
         .INIT_WORD (INIT_W[g])
      ) u_dut (
         .clk       (clk),
         .RSTn      (RSTn),
         .top_valid (tv[g]),
         .spi_cs    (cs[g]),
         .spi_clk   (sck[g]),
         .spi_data  (sdo[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Monitor state: frame decode per instance, model counts frames since reset
   logic        rst_e = 1'b0;
   logic [1:0]  pcs   = 2'b11;
   logic [1:0]  psck  = 2'b00;
   logic [1:0]  infr  = 2'b00;
   int          nbits  [2];
   int          low    [2];
   int          nstart [2];
   int          ndone  [2];
   logic [15:0] word   [2];
   logic [15:0] last_w [2];
   int          cyc = 0;
   int          last_fall = 0;
   bit          have_fall = 0;
   bit          stream_chk = 0;

   always @(posedge clk) rst_e = RSTn;

   always @(negedge clk) begin
      logic [15:0] expw;
      cyc++;
      for (int g = 0; g < 2; g++) begin
         if (rst_e) begin
            chk("rst_cs", cs[g], 1);
            chk("rst_clk", sck[g], 0);
            chk("rst_data", sdo[g], 0);
            infr[g]   = 1'b0;
            nstart[g] = 0;
            ndone[g]  = 0;
         end else begin
            if (cs[g]) chk("clk_while_cs_high", sck[g], 0);
            if (pcs[g] && !cs[g]) begin
               infr[g]  = 1'b1;
               nbits[g] = 0;
               low[g]   = 0;
               word[g]  = '0;
               nstart[g]++;
               if (g == 0) begin
                  if (stream_chk && have_fall)
                     chk("period", cyc - last_fall, PERIOD);
                  last_fall = cyc;
                  have_fall = 1;
               end
            end
            if (infr[g] && !cs[g]) begin
               if (!psck[g] && sck[g]) begin
                  if (nbits[g] == 0) chk("first_rise", low[g], FIRST_R);
                  word[g] = {word[g][14:0], sdo[g]};
                  nbits[g]++;
               end
               low[g]++;
            end
            if (infr[g] && !pcs[g] && cs[g]) begin
               expw = INIT_W[g] + 16'(ndone[g]);
               chk("nbits", nbits[g], 16);
               chk("cs_low", low[g], CS_LOW);
               chk("payload", word[g], expw);
               last_w[g] = word[g];
               ndone[g]++;
               infr[g] = 1'b0;
            end
         end
         pcs[g]  = cs[g];
         psck[g] = sck[g];
      end
      if (!stream_chk) have_fall = 0;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_bits(input int g, input int n, input int budget);
      int k = 0;
      while (!(infr[g] && nbits[g] >= n) && k < budget) begin
         tick();
         k++;
      end
      chk("wait_bits_timeout", k < budget, 1);
   endtask

   task automatic wait_idle(input int g, input int budget);
      int k = 0;
      while ((infr[g] || cs[g] == 1'b0) && k < budget) begin
         tick();
         k++;
      end
      chk("wait_idle_timeout", k < budget, 1);
   endtask

   int base;
   int k;
   int len;

   initial begin
      RSTn = 1'b1;
      tv   = 2'b00;

      // Reset, then a long quiet period
      tick(3);
      RSTn = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle_cs", cs[0], 1);
         chk("idle_clk", sck[0], 0);
         chk("idle_data", sdo[0], 0);
      end

      // Single one-cycle request
      tick();
      tv[0] = 1'b1;
      @(negedge clk);
      chk("no_early_cs", cs[0], 1);
      tick();
      tv[0] = 1'b0;
      @(negedge clk);
      chk("latency", cs[0], 0);
      wait_idle(0, 200);
      tick(120);
      chk("single_frames", nstart[0], 1);
      chk("single_done", ndone[0], 1);

      // Streaming for 50 us (2500 sampled edges)
      base = nstart[0];
      stream_chk = 1;
      tv[0] = 1'b1;
      tick(2500);
      tv[0] = 1'b0;
      stream_chk = 0;
      wait_idle(0, 200);
      tick(150);
      chk("stream_frames", nstart[0] - base, 1 + (2500 - 1) / PERIOD);
      chk("stream_done", ndone[0], nstart[0]);

      // Drop request mid-frame after k rising edges
      for (int it = 0; it < 4; it++) begin
         k = (it == 0) ? 5 : int'($urandom_range(15, 1));
         base = nstart[0];
         tv[0] = 1'b1;
         wait_bits(0, k, 400);
         tv[0] = 1'b0;
         wait_idle(0, 200);
         tick(100 + int'($urandom_range(20)));
         chk("drop_frames", nstart[0] - base, 1);
         chk("drop_done", ndone[0], nstart[0]);
      end

      // Random-length requests: frames start every PERIOD sampled edges
      for (int it = 0; it < 4; it++) begin
         tick(int'($urandom_range(30)));
         len  = int'($urandom_range(220, 1));
         base = nstart[0];
         tv[0] = 1'b1;
         tick(len);
         tv[0] = 1'b0;
         wait_idle(0, 200);
         tick(100);
         chk("pulse_frames", nstart[0] - base, 1 + (len - 1) / PERIOD);
      end

      // Counter wrap on the FFFF instance
      tv[1] = 1'b1;
      k = 0;
      while (nstart[1] < 2 && k < 300) begin
         tick();
         k++;
      end
      tv[1] = 1'b0;
      chk("wrap_timeout", k < 300, 1);
      wait_idle(1, 200);
      tick(50);
      chk("wrap_frames", ndone[1], 2);
      chk("wrap_last", last_w[1], 16'h0000);

      // Reset in the middle of SHIFT
      tv[0] = 1'b1;
      tick();
      tv[0] = 1'b0;
      wait_bits(0, int'($urandom_range(12, 2)), 200);
      RSTn = 1'b1;
      tick();
      RSTn = 1'b0;
      @(negedge clk);
      chk("abort_cs", cs[0], 1);
      chk("abort_clk", sck[0], 0);
      tick(20);
      tv[0] = 1'b1;
      tick();
      tv[0] = 1'b0;
      wait_idle(0, 200);
      tick(50);
      chk("post_rst_frames", ndone[0], 1);
      chk("post_rst_word", last_w[0], 16'hA5A5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
